// File: rtl/gat_seq_pkg.sv
// Shared constants for the GAT layer sequencer: FSM encoding and sizing helpers.
package gat_seq_pkg;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WAIT_LOAD = 3'd1;
   localparam logic [2:0] S_RUN       = 3'd2;
   localparam logic [2:0] S_DRAIN     = 3'd3;
   localparam logic [2:0] S_NEXT      = 3'd4;
   localparam logic [2:0] S_DONE      = 3'd5;

   localparam int DEF_NUM_SUBGRAPHS   = 2708;
   localparam int DEF_NUM_FEATURE_OUT = 16;

   function automatic int word_addr_w(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/gat_layer_sequencer_if.sv
// Valid/ready feature stream carrying the drained new-feature BRAM words.
interface gat_layer_sequencer_if #(parameter int W = 32);
   logic [W-1:0] data;
   logic         valid;
   logic         ready;
   logic         last;

   modport master (output data, valid, last, input ready);
   modport slave  (input data, valid, last, output ready);
endinterface

// File: rtl/gat_feat_skid.sv
// Two-entry skid FIFO behind a 1-cycle-latency BRAM read port, tracking the read in flight.
module gat_feat_skid #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         issue,
   input  logic         issue_last,
   input  logic [W-1:0] rdata,
   output logic         can_issue,
   output logic [W-1:0] data,
   output logic         valid,
   output logic         last,
   input  logic         ready
);

   logic [1:0][W:0] mem;
   logic            wr_ptr, rd_ptr;
   logic [1:0]      count;
   logic            in_flight, in_flight_last;
   logic            push, pop;
   logic [2:0]      occupancy;

   assign push  = in_flight;
   assign pop   = valid & ready;
   assign valid = (count != 2'd0);
   assign {last, data} = mem[rd_ptr];

   // Occupancy is taken after this cycle's pop so a held-ready sink gets one word per clock.
   assign occupancy = {1'b0, count} - {2'b0, pop} + {2'b0, in_flight};
   assign can_issue = (occupancy < 3'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem            <= '0;
         wr_ptr         <= 1'b0;
         rd_ptr         <= 1'b0;
         count          <= 2'd0;
         in_flight      <= 1'b0;
         in_flight_last <= 1'b0;
      end else begin
         in_flight      <= issue;
         in_flight_last <= issue_last;
         if (push) begin
            mem[wr_ptr] <= {in_flight_last, rdata};
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/gat_layer_sequencer.sv
// Run-time controller for the GAT core: gates load flags, selects the layer,
// waits for layer completion and streams the new-feature BRAM out.
module gat_layer_sequencer
   import gat_seq_pkg::*;
#(
   parameter int TOP_WIDTH          = 32,
   parameter int NEW_FEATURE_WIDTH  = 32,
   parameter int NUM_SUBGRAPHS      = DEF_NUM_SUBGRAPHS,
   parameter int NUM_FEATURE_OUT    = DEF_NUM_FEATURE_OUT,
   parameter int NUM_LAYERS         = 2,
   parameter int TIMEOUT_W          = 24,
   localparam int NUM_WORDS          = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
   localparam int NEW_FEATURE_ADDR_W = word_addr_w(NUM_WORDS)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic                            h_data_ld_i,
   input  logic                            h_node_info_ld_i,
   input  logic                            wgt_ld_i,
   output logic                            h_data_bram_load_done,
   output logic                            h_node_info_bram_load_done,
   output logic                            wgt_bram_load_done,
   output logic                            gat_layer,
   input  logic                            gat_ready,
   output logic [NEW_FEATURE_ADDR_W+1:0]   feat_bram_addrb,
   input  logic [NEW_FEATURE_WIDTH-1:0]    feat_bram_dout,
   gat_layer_sequencer_if.master           m,
   output logic                            busy,
   output logic                            done,
   output logic                            layer_idx,
   output logic                            err_timeout
);

   // Watchdog kept no wider than the host bus so it stays readable there.
   localparam int WD_W = (TIMEOUT_W < TOP_WIDTH) ? TIMEOUT_W : TOP_WIDTH;
   localparam logic [NEW_FEATURE_ADDR_W-1:0] LAST_IDX = NEW_FEATURE_ADDR_W'(NUM_WORDS - 1);

   logic [2:0]                    state;
   logic                          ready_q, layer_q, err_q;
   logic [WD_W-1:0]               wd;
   logic [NEW_FEATURE_ADDR_W-1:0] cnt;
   logic                          issued_all, issue, can_issue;
   logic                          all_ld, ready_rise, last_hs, ld_out;

   assign all_ld     = h_data_ld_i & h_node_info_ld_i & wgt_ld_i;
   assign ready_rise = gat_ready & ~ready_q;
   assign issue      = (state == S_DRAIN) & ~issued_all & can_issue;
   assign last_hs    = m.valid & m.ready & m.last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         ready_q    <= 1'b0;
         layer_q    <= 1'b0;
         err_q      <= 1'b0;
         wd         <= '0;
         cnt        <= '0;
         issued_all <= 1'b0;
      end else begin
         ready_q <= gat_ready;
         case (state)
            S_IDLE, S_DONE: if (start) begin
               state   <= S_WAIT_LOAD;
               layer_q <= 1'b0;
               err_q   <= 1'b0;
            end
            S_WAIT_LOAD: if (all_ld) begin
               state <= S_RUN;
               wd    <= WD_W'(1);
            end
            // wd holds the 1-based index of the current RUN cycle
            S_RUN: begin
               if (ready_rise) state <= S_DRAIN;
               else if (&wd) begin
                  err_q <= 1'b1;
                  state <= S_DONE;
               end else wd <= wd + 1'b1;
            end
            S_DRAIN: begin
               if (issue) begin
                  if (cnt == LAST_IDX) issued_all <= 1'b1;
                  else                 cnt        <= cnt + 1'b1;
               end
               if (last_hs) begin
                  state      <= S_NEXT;
                  cnt        <= '0;
                  issued_all <= 1'b0;
               end
            end
            S_NEXT: begin
               if (int'(layer_q) < NUM_LAYERS - 1) begin
                  layer_q <= 1'b1;
                  state   <= S_WAIT_LOAD;
               end else state <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   gat_feat_skid #(.W(NEW_FEATURE_WIDTH)) u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .issue      (issue),
      .issue_last (cnt == LAST_IDX),
      .rdata      (feat_bram_dout),
      .can_issue  (can_issue),
      .data       (m.data),
      .valid      (m.valid),
      .last       (m.last),
      .ready      (m.ready)
   );

   // Flags stay up through DRAIN; NEXT drops them so the core sees a fresh edge.
   assign ld_out                     = (state == S_RUN) | (state == S_DRAIN);
   assign h_data_bram_load_done      = ld_out;
   assign h_node_info_bram_load_done = ld_out;
   assign wgt_bram_load_done         = ld_out;
   assign gat_layer                  = layer_q;
   assign layer_idx                  = layer_q;
   assign err_timeout                = err_q;
   assign feat_bram_addrb            = {cnt, 2'b00};
   assign busy = (state == S_WAIT_LOAD) | (state == S_RUN) | (state == S_DRAIN) | (state == S_NEXT);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_gat_layer_sequencer.sv
// Self-checking bench for gat_layer_sequencer: scoreboarded BRAM drain plus control corner cases.
module tb_gat_layer_sequencer;

   localparam int W   = 32;
   localparam int NSG = 9;
   localparam int NFO = 16;
   localparam int NW  = NSG * NFO;
   localparam int AW  = $clog2(NW);
   localparam int AWB = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, start, start_b, h_ld, n_ld, w_ld, gat_ready, rnd_ready;
   logic h_done, n_done, w_done, gat_layer, busy, done, layer_idx, err;
   logic [AW+1:0] addrb;
   logic [W-1:0]  dout;
   logic b_h_done, b_n_done, b_w_done, b_gat_layer, b_busy, b_done, b_layer_idx, b_err;
   logic [AWB+1:0] b_addrb;
   logic [W-1:0]   b_dout;
   logic           b_gat_ready;

   gat_layer_sequencer_if #(.W(W)) s ();
   gat_layer_sequencer_if #(.W(W)) sb ();

   gat_layer_sequencer #(.NUM_SUBGRAPHS(NSG), .NUM_FEATURE_OUT(NFO), .NUM_LAYERS(2),
                         .TIMEOUT_W(10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .h_data_ld_i(h_ld), .h_node_info_ld_i(n_ld), .wgt_ld_i(w_ld),
      .h_data_bram_load_done(h_done), .h_node_info_bram_load_done(n_done),
      .wgt_bram_load_done(w_done), .gat_layer(gat_layer), .gat_ready(gat_ready),
      .feat_bram_addrb(addrb), .feat_bram_dout(dout), .m(s),
      .busy(busy), .done(done), .layer_idx(layer_idx), .err_timeout(err));

   gat_layer_sequencer #(.NUM_SUBGRAPHS(1), .NUM_FEATURE_OUT(4), .NUM_LAYERS(1),
                         .TIMEOUT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b),
      .h_data_ld_i(h_ld), .h_node_info_ld_i(n_ld), .wgt_ld_i(w_ld),
      .h_data_bram_load_done(b_h_done), .h_node_info_bram_load_done(b_n_done),
      .wgt_bram_load_done(b_w_done), .gat_layer(b_gat_layer), .gat_ready(b_gat_ready),
      .feat_bram_addrb(b_addrb), .feat_bram_dout(b_dout), .m(sb),
      .busy(b_busy), .done(b_done), .layer_idx(b_layer_idx), .err_timeout(b_err));

   assign b_dout      = '0;
   assign b_gat_ready = 1'b0;

   function automatic logic [W-1:0] word(input logic l, input int i);
      return {7'h35, l, 8'hA0, 16'(i * 7 + 3)};
   endfunction

   // BRAM model: one-cycle read latency, contents keyed by layer and word index
   always @(posedge clk) dout <= word(gat_layer, int'(addrb >> 2));

   int n_pass = 0, n_tot = 0;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   typedef struct packed { logic last; logic [W-1:0] data; } beat_t;
   beat_t exp_q[$];
   int    cyc = 0, hs_cnt = 0, first_cyc = -1, last_cyc = 0;
   logic  hold_v = 1'b0;
   beat_t hold_b;
   logic [AW+1:0] prev_a = '0;

   always @(posedge clk) cyc++;

   // Stream monitor: stability under back-pressure, then in-order scoreboard pop
   always @(negedge clk) begin
      if (hold_v && rst_n) chk("stall_hold", {s.valid, s.last, s.data}, {1'b1, hold_b});
      hold_v = s.valid & ~s.ready;
      hold_b = {s.last, s.data};
      if (s.valid && s.ready) begin
         hs_cnt++;
         if (exp_q.size() == 0) chk("sb_empty_on_word", exp_q.size(), 1);
         else begin
            beat_t b;
            b = exp_q.pop_front();
            chk("stream_word", {s.last, s.data}, b);
            if (first_cyc < 0) first_cyc = cyc;
            if (b.last) last_cyc = cyc;
         end
      end
      if (addrb !== prev_a) begin
         if (addrb != 0) chk("addr_step", addrb, prev_a + 4);
         prev_a = addrb;
      end
   end

   always @(posedge clk) begin
      #2;
      if (rnd_ready) s.ready = 1'($urandom_range(0, 1));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_layer(input logic l);
      for (int i = 0; i < NW; i++) exp_q.push_back({(i == NW - 1), word(l, i)});
   endtask

   task automatic wait_run();
      for (int k = 0; k < 200 && !h_done; k++) tick();
      chk("run_entry", h_done, 1);
   endtask

   task automatic wait_drained();
      for (int k = 0; k < 4000 && exp_q.size() != 0; k++) tick();
      chk("drain_complete", exp_q.size(), 0);
   endtask

   typedef struct { logic h, n, w; logic exp_ld; } ld_vec_t;
   ld_vec_t ld_tab[7];

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base, n_run;
      ld_tab[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
      ld_tab[1] = '{1'b1, 1'b1, 1'b0, 1'b0};
      ld_tab[2] = '{1'b1, 1'b1, 1'b0, 1'b0};
      ld_tab[3] = '{1'b1, 1'b0, 1'b1, 1'b0};
      ld_tab[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      ld_tab[5] = '{1'b1, 1'b1, 1'b0, 1'b0};
      ld_tab[6] = '{1'b1, 1'b1, 1'b1, 1'b1};

      start = 0; start_b = 0; h_ld = 0; n_ld = 0; w_ld = 0; gat_ready = 0;
      rnd_ready = 0; s.ready = 0; sb.ready = 1; rst_n = 0;
      repeat (3) @(negedge clk);
      chk("rst_status", {busy, done, err, layer_idx, gat_layer}, 0);
      chk("rst_load_done", {h_done, n_done, w_done}, 0);
      chk("rst_stream", {s.valid, s.last, s.data}, 0);
      chk("rst_addr", addrb, 0);
      tick();
      rst_n = 1;

      // Run 1: full two-layer pass, layer 2 sees a stale-high ready and random back-pressure
      h_ld = 1; n_ld = 1; w_ld = 1; s.ready = 1;
      tick(); start = 1; tick(); start = 0;
      chk("start_busy", {busy, done}, 2'b10);
      wait_run();
      chk("layer0_select", {gat_layer, layer_idx}, 2'b00);
      repeat (50) tick();
      push_layer(1'b0); first_cyc = -1;
      gat_ready = 1;
      wait_drained();
      chk("next_load_done_low", {h_done, n_done, w_done}, 0);
      chk("next_busy", busy, 1);
      chk("throughput_1_per_clk", last_cyc - first_cyc + 1, NW);
      wait_run();
      chk("layer1_select", {gat_layer, layer_idx}, 2'b11);
      repeat (20) tick();
      chk("stale_ready_ignored", {h_done, s.valid, busy}, 3'b101);
      gat_ready = 0; tick(); tick();
      push_layer(1'b1); rnd_ready = 1;
      gat_ready = 1;
      wait_drained();
      rnd_ready = 0; s.ready = 1; gat_ready = 0;
      tick();
      chk("done_after_two", {done, busy, err}, 3'b100);

      // Run 2: load gating table, then reset in the middle of the drain
      h_ld = 0; n_ld = 0; w_ld = 0;
      tick(); start = 1; tick(); start = 0;
      chk("restart_clears_done", {busy, done}, 2'b10);
      for (int i = 0; i < 7; i++) begin
         h_ld = ld_tab[i].h; n_ld = ld_tab[i].n; w_ld = ld_tab[i].w;
         tick();
         chk($sformatf("ld_gate_%0d", i), {h_done, n_done, w_done, busy},
             {{3{ld_tab[i].exp_ld}}, 1'b1});
      end
      repeat (10) tick();
      push_layer(1'b0);
      gat_ready = 1;
      base = hs_cnt;
      for (int k = 0; k < 1000 && hs_cnt - base < 100; k++) tick();
      chk("reach_word100", (hs_cnt - base >= 100), 1);
      rst_n = 0;
      #1;
      chk("midrun_rst_status", {busy, done, err, layer_idx, gat_layer, h_done, n_done, w_done}, 0);
      chk("midrun_rst_stream", {s.valid, s.last, s.data, addrb}, 0);
      exp_q.delete();
      gat_ready = 0;
      tick();
      rst_n = 1;

      // Run 3: re-drain from address 0 under random back-pressure, start ignored while busy
      tick(); start = 1; tick(); start = 0;
      wait_run();
      start = 1; tick(); start = 0;
      chk("start_ignored_busy", {h_done, busy, layer_idx}, 3'b110);
      push_layer(1'b0); rnd_ready = 1;
      gat_ready = 1;
      wait_drained();
      gat_ready = 0;
      wait_run();
      repeat (5) tick();
      push_layer(1'b1);
      gat_ready = 1;
      wait_drained();
      rnd_ready = 0; s.ready = 1; gat_ready = 0;
      tick();
      chk("run3_done", {done, busy}, 2'b10);

      // Watchdog on the narrow-timeout instance
      start_b = 1; tick(); start_b = 0;
      n_run = 0;
      for (int k = 0; k < 100 && !b_done; k++) begin
         tick();
         if (b_h_done) n_run++;
      end
      chk("wd_run_cycles", n_run, 15);
      chk("wd_err_state", {b_err, b_done, b_busy}, 3'b110);
      chk("wd_quiet_outputs", {b_n_done, b_w_done, b_gat_layer, b_layer_idx, sb.valid, sb.last,
                               b_addrb, sb.data}, 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
